// File: rtl/lut_layer_pkg.sv
// rtl/lut_layer_pkg.sv - shared types and helpers for the programmable LUT layer
package lut_layer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PROG  = 2'd2
  } state_t;

  // A select port needs at least one bit even for a single-neuron layer.
  function automatic int neur_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_tbl.sv
// rtl/lut_neuron_tbl.sv - one neuron truth table, sync write, async read
module lut_neuron_tbl #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
);

  // No reset: contents survive rst_n so a layer need not be reprogrammed.
  logic [OUT_BITS-1:0] mem [2**IN_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_layer_prog.sv
// rtl/lut_layer_prog.sv - programmable LUT layer with one registered lookup stage
module lut_layer_prog
  import lut_layer_pkg::*;
#(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 1,
  parameter int NUM_NEURONS = 4,
  parameter int NEUR_W      = neur_w(NUM_NEURONS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [NEUR_W-1:0]               cfg_neuron,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            cfg_last,
  output logic                            busy
);

  state_t                            state;
  logic                              in_xfer;
  logic                              out_xfer;
  logic                              cfg_xfer;
  logic [NUM_NEURONS*OUT_BITS-1:0]   lookup;
  logic [NUM_NEURONS-1:0]            we;

  // Pending config blocks new data so the drain can finish.
  assign in_ready = (state == RUN) && !cfg_valid && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign cfg_xfer = cfg_valid && cfg_ready && rst_n;

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    assign we[n] = cfg_xfer && (cfg_neuron == NEUR_W'(n));

    lut_neuron_tbl #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_tbl (
      .clk   (clk),
      .we    (we[n]),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (in_data[n*IN_BITS +: IN_BITS]),
      .rdata (lookup[n*OUT_BITS +: OUT_BITS])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= lookup;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end

      case (state)
        RUN: begin
          if (cfg_valid) begin
            busy <= 1'b1;
            if (out_valid) begin
              state <= DRAIN;
            end else begin
              state     <= PROG;
              cfg_ready <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Output register is empty after this edge, so writes may start.
          if (!out_valid || out_ready) begin
            state     <= PROG;
            cfg_ready <= 1'b1;
          end
        end
        PROG: begin
          if (cfg_xfer && cfg_last) begin
            state     <= RUN;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_layer_prog.sv
// tb/tb_lut_layer_prog.sv - randomized self-checking bench for lut_layer_prog
module tb_lut_layer_prog;

  localparam int IB = 6;
  localparam int OB = 1;
  localparam int NN = 3;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NN*IB-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [NN*OB-1:0] out_data;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [NW-1:0]   cfg_neuron;
  logic [IB-1:0]   cfg_addr;
  logic [OB-1:0]   cfg_data;
  logic            cfg_last;
  logic            busy;

  int n_err = 0;
  int n_chk = 0;

  bit               model [NN][64];
  logic [NN*IB-1:0] pend_q [$];
  logic [NN*OB-1:0] exp_q  [$];

  always #5 clk = ~clk;

  lut_layer_prog #(
    .IN_BITS     (IB),
    .OUT_BITS    (OB),
    .NUM_NEURONS (NN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_fn(input logic [5:0] x);
    return (x[0] & ~x[5]) ^ (x[2] & x[4]);
  endfunction

  function automatic logic [NN*OB-1:0] model_out(input logic [NN*IB-1:0] d);
    logic [NN*OB-1:0] r;
    r = '0;
    for (int n = 0; n < NN; n++) r[n] = model[n][d[n*IB +: IB]];
    return r;
  endfunction

  // Tasks start and end just after a rising edge.
  task automatic cfg_write(input int nn, input int a, input bit d, input bit last);
    bit done;
    done       = 1'b0;
    cfg_valid  = 1'b1;
    cfg_neuron = NW'(nn);
    cfg_addr   = IB'(a);
    cfg_data   = OB'(d);
    cfg_last   = last;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (cfg_ready) begin
        if (nn < NN) model[nn][a] = d;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (!done) check("cfg_timeout", 0, 1);
  endtask

  task automatic run_stream(input int rdy_pct, input int vld_pct);
    bit               acc, prev_acc, prev_stall;
    logic [NN*OB-1:0] prev_data;
    int               guard;
    prev_acc   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    guard      = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && guard < 3000) begin
      in_valid  = (pend_q.size() > 0) && ($urandom_range(99) < vld_pct);
      in_data   = (pend_q.size() > 0) ? pend_q[0] : '0;
      out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      acc = in_valid && in_ready;
      if (prev_acc) check("latency", out_valid, 1);
      if (prev_stall) check("hold", out_data, prev_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("data", out_data, exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(model_out(in_data));
        void'(pend_q.pop_front());
      end
      prev_acc = acc;
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) check("stream_timeout", 0, 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic lookup_one(input logic [NN*IB-1:0] d, output logic [NN*OB-1:0] r);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("lk_accept", ok, 1);
    check("lk_valid", out_valid, 1);
    r         = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NN*OB-1:0] r;
    logic [NN*OB-1:0] hold_val;
    logic [NN*IB-1:0] v [4];
    logic [NN*IB-1:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_valid = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 128; i++) cfg_write(1 + i / 64, i % 64, bit'($urandom_range(1)), i == 127);
    for (int a = 0; a < 64; a++) cfg_write(0, a, ref_fn(6'(a)), a == 63);
    check("prog_done_busy", busy, 0);

    for (int i = 0; i < 64; i++) pend_q.push_back({12'($urandom), 6'(i)});
    run_stream(100, 100);
    lookup_one({12'($urandom), 6'b100000}, r);
    check("n0_100000", r[0], 0);
    lookup_one({12'($urandom), 6'b000001}, r);
    check("n0_000001", r[0], 1);
    lookup_one({12'($urandom), 6'b111011}, r);
    check("n0_111011", r[0], 0);

    // Backpressure: one accept, then output stalls with input pending.
    for (int i = 0; i < 4; i++) v[i] = 18'($urandom);
    in_valid = 1'b1; in_data = v[0]; out_ready = 1'b0;
    #1;
    check("bp_first_ready", in_ready, 1);
    @(posedge clk); #1;
    exp_q.push_back(model_out(v[0]));
    in_data  = v[1];
    hold_val = out_data;
    check("bp_out_valid", out_valid, 1);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_stable", out_data, hold_val);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) pend_q.push_back(v[i]);
    run_stream(100, 100);

    // Config arriving while the output register is full.
    d = 18'($urandom);
    in_valid = 1'b1; in_data = d; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hold_val = model_out(d);
    check("ct_out_valid", out_valid, 1);
    cfg_valid = 1'b1; cfg_neuron = 2'd1; cfg_addr = 6'd0; cfg_data = 1'b1; cfg_last = 1'b1;
    in_valid = 1'b1;
    #1;
    check("ct_in_blocked", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ct_drain_busy", busy, 1);
    check("ct_drain_cfg_ready", cfg_ready, 0);
    out_ready = 1'b1;
    #1;
    check("ct_drained_data", out_data, hold_val);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ct_prog_out_valid", out_valid, 0);
    check("ct_prog_cfg_ready", cfg_ready, 1);
    check("ct_prog_busy", busy, 1);
    model[1][0] = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_last = 1'b0;
    check("ct_back_run", busy, 0);
    lookup_one('0, r);
    check("ct_n1_entry0", r[1], 1);
    check("ct_n0_entry0", r[0], 0);

    // Paused burst.
    for (int a = 5; a < 8; a++) cfg_write(2, a, !model[2][a], 1'b0);
    in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("pause_busy", busy, 1);
      check("pause_cfg_ready", cfg_ready, 1);
      check("pause_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("pause_no_out", out_valid, 0);
    cfg_write(2, 8, !model[2][8], 1'b1);
    check("pause_done", busy, 0);
    for (int a = 5; a < 9; a++) pend_q.push_back({6'(a), 12'($urandom)});
    run_stream(70, 80);

    // Out-of-range neuron select is accepted and dropped.
    cfg_write(3, 10, 1'b1, 1'b0);
    cfg_write(3, 11, 1'b0, 1'b1);
    check("oor_done", busy, 0);
    for (int i = 0; i < 64; i++) pend_q.push_back({6'(i), 6'(i), 6'(i)});
    run_stream(70, 80);

    // Reset in the middle of a burst.
    for (int i = 0; i < 10; i++) begin
      int nn, aa;
      nn = $urandom_range(NN - 1);
      aa = $urandom_range(63);
      cfg_write(nn, aa, !model[nn][aa], 1'b0);
    end
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cfg_ready", cfg_ready, 0);
    check("mrst_in_ready", in_ready, 1);
    for (int i = 0; i < 64; i++) pend_q.push_back({6'(i), 6'(i), 6'(i)});
    run_stream(60, 90);

    for (int i = 0; i < 200; i++) pend_q.push_back(18'($urandom));
    run_stream(40 + $urandom_range(60), 50 + $urandom_range(50));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lut_layer_prog.md
Name: lut_layer_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed truth-table neurons in the generated layers.
- Holds NUM_NEURONS truth tables, each with 2^IN_BITS entries of OUT_BITS. Every neuron looks up its own IN_BITS slice of the input vector.
- One registered lookup stage with valid/ready on both sides, so layers chain into a pipelined network.
- A config port reloads the tables in-system. The block drains in-flight data before any table write.

Parameters:
- IN_BITS, 6, fan-in bits per neuron (table address width).
- OUT_BITS, 1, output bits per neuron (table word width).
- NUM_NEURONS, 4, neurons in the layer.
- NEUR_W, $clog2(NUM_NEURONS) (min 1), derived, neuron-select width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  NUM_NEURONS*IN_BITS  neuron n uses bits [n*IN_BITS +: IN_BITS].
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  NUM_NEURONS*OUT_BITS  neuron n drives bits [n*OUT_BITS +: OUT_BITS].
- cfg_valid  in  1  table write request.
- cfg_ready  out  1  write accepted this cycle.
- cfg_neuron  in  NEUR_W  target neuron.
- cfg_addr  in  IN_BITS  table entry.
- cfg_data  in  OUT_BITS  entry value.
- cfg_last  in  1  final write of the programming burst.
- busy  out  1  high in DRAIN or PROG.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge):
  - state=RUN; out_valid=0; out_data=0; cfg_ready=0; busy=0.
  - Table contents are NOT reset (distributed storage); they hold their values across reset.
  - Reset mid-burst abandons PROG. Entries already written keep their new values.
- Handshakes: in transfer = in_valid&&in_ready; out transfer = out_valid&&out_ready; cfg transfer = cfg_valid&&cfg_ready.
- in_ready = (state==RUN) && !cfg_valid && (!out_valid || out_ready). Pending config has priority over new data.
- Latency: exactly 1 cycle. On an in transfer, out_data[n] <= table[n][in_data slice n] and out_valid <= 1 at the same edge.
- Output register: holds out_data stable while out_valid&&!out_ready. It clears out_valid on an out transfer with no concurrent in transfer.
- Back-to-back: an in transfer and an out transfer in the same cycle sustain 1 vector/cycle.
- FSM:
  - RUN: if cfg_valid then go to DRAIN if out_valid, else go to PROG.
  - DRAIN: in_ready=0; leave for PROG when out_valid=0 (after the out transfer completes).
  - PROG: cfg_ready=1, in_ready=0. On each cfg transfer, table[cfg_neuron][cfg_addr] <= cfg_data. A cfg transfer with cfg_last=1 returns to RUN next cycle.
  - cfg_valid dropping in PROG without cfg_last: stay in PROG (burst may pause).
- Write visibility: a table write is visible to the first input accepted after return to RUN. No lookup ever sees a partially applied burst mid-vector.
- cfg_neuron >= NUM_NEURONS: the write is accepted (cfg_ready=1) and discarded.
- Simultaneous cfg_valid and in_valid in RUN: the input is not accepted, and config proceeds.
- cfg_ready is 0 outside PROG. cfg_valid outside PROG only triggers the RUN to DRAIN/PROG transition.
- Width rules: all slicing is fixed by parameters; no arithmetic beyond the FSM.

Decomposition:
- Shared package lut_layer_pkg: state enum (RUN, DRAIN, PROG) and a function for the NEUR_W clog2-min-1 rule.
- One natural sub-module, lut_neuron_tbl: a single neuron's 2^IN_BITS x OUT_BITS table with write port (we, waddr, wdata) and combinational read port (raddr, rdata). The top instantiates NUM_NEURONS copies via generate; we = cfg transfer && cfg_neuron==n.
- The top owns the FSM and output register.

Test Plan:
- Program the reference neuron-105 function into neuron 0 (64 writes, cfg_last on the 64th). Stream all 64 inputs with out_ready=1 -> out_valid one cycle after each accept; out_data[0] matches the truth table, e.g. 6'b100000->0, 6'b000001->1, 6'b111011->0.
- Backpressure: stream 4 vectors, hold out_ready=0 for 5 cycles -> in_ready=0 from cycle 2; out_data stable; no loss or duplication after release, order preserved.
- Config during traffic: out_valid=1, out_ready=0, assert cfg_valid -> state DRAIN, cfg_ready=0. Raise out_ready -> next cycle PROG, cfg_ready=1, busy=1. Write entry 0 of neuron 1 = 1 with cfg_last -> RUN; input 0 gives out_data[1]=1.
- Paused burst: cfg_valid low for 3 cycles mid-burst without cfg_last -> remains PROG, in_ready=0; resume completes normally.
- Out-of-range: NUM_NEURONS=3, cfg_neuron=3 write -> accepted; all three tables unchanged.
- Reset in PROG after 10 writes -> RUN, out_valid=0, busy=0; the 10 written entries retain their new values.
